i2c_fifo: RTL and testbench

- Synchronous show-ahead FIFO between the APB front-end and the I2C core.
- Two instances are used:
  - TX path: the APB front-end pushes through its write-enable and write-data outputs, and the I2C core pops.
  - RX path: the I2C core pushes, and the APB front-end pops through its read-enable and read-data inputs.
- Provides EMPTY and ALMOST_FULL status that drives the front-end's TX_EMPTY/RX_EMPTY interrupt inputs. Also provides sticky overflow/underflow flags that feed the ERROR/PSLVERR path.

---
 rtl/i2c_fifo_pkg.sv | 18 +
 rtl/i2c_fifo_mem.sv | 34 +++
 rtl/i2c_fifo.sv | 116 +++++++++++
 tb/tb_i2c_fifo.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_fifo_pkg.sv
// Shared definitions for the I2C controller FIFOs and the APB front-end.
//   I2C_DWIDTH     : data word width of the controller
//   I2C_FIFO_DEPTH : default FIFO depth
//   i2c_word_t     : one data word
//   fifo_level_w() : width of an occupancy count (0..depth inclusive)
package i2c_fifo_pkg;

    localparam int unsigned I2C_DWIDTH     = 32;
    localparam int unsigned I2C_FIFO_DEPTH = 8;

    typedef logic [I2C_DWIDTH-1:0] i2c_word_t;

    // Occupancy needs one extra bit so that a full FIFO (level == depth) is representable.
    function automatic int unsigned fifo_level_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/i2c_fifo_mem.sv
// DEPTH x DWIDTH storage for i2c_fifo: registered write port, asynchronous read port.
//   clk      : write clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data (combinational from raddr_i)
// No reset and no control logic; contents are undefined until written.
module fifo_mem #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DWIDTH-1:0] rdata_o
);

    logic [DWIDTH-1:0] mem_q [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/i2c_fifo.sv
// Synchronous show-ahead FIFO between the APB front-end and the I2C core.
//   PCLK, PRESETn      : clock, asynchronous active-low reset
//   WR_EN, DATA_IN     : push request and pushed word
//   RD_EN, DATA_OUT    : pop request and head word (zero while EMPTY)
//   EMPTY, FULL        : occupancy extremes
//   ALMOST_FULL, LEVEL : LEVEL >= AF_LEVEL, current occupancy 0..DEPTH
//   OVERFLOW/UNDERFLOW : sticky rejected-push / rejected-pop flags
//   ERR_CLR            : synchronous clear of the sticky flags (a new error wins)
module i2c_fifo
    import i2c_fifo_pkg::*;
#(
    parameter int unsigned DWIDTH   = I2C_DWIDTH,
    parameter int unsigned DEPTH    = I2C_FIFO_DEPTH,
    parameter int unsigned AF_LEVEL = 6
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    input  logic                           WR_EN,
    input  logic [DWIDTH-1:0]              DATA_IN,
    input  logic                           RD_EN,
    output logic [DWIDTH-1:0]              DATA_OUT,
    output logic                           EMPTY,
    output logic                           FULL,
    output logic                           ALMOST_FULL,
    output logic [fifo_level_w(DEPTH)-1:0] LEVEL,
    output logic                           OVERFLOW,
    output logic                           UNDERFLOW,
    input  logic                           ERR_CLR
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = fifo_level_w(DEPTH);

    // Elaboration-time parameter check.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("i2c_fifo: DEPTH must be a power of two and at least 2");
    end
    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
        $error("i2c_fifo: AF_LEVEL must be in 1..DEPTH");
    end

    logic [LW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              empty_c, full_c;
    logic              push_ok_c, pop_ok_c;
    logic [LW-1:0]     level_c;
    logic [DWIDTH-1:0] rdata_c;

    // Status from the registered pointers; MSB is the wrap bit.
    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign level_c = wr_ptr_q - rd_ptr_q;

    // A push into a full FIFO is fine when a pop frees a slot at the same edge.
    assign pop_ok_c  = RD_EN && !empty_c;
    assign push_ok_c = WR_EN && (!full_c || pop_ok_c);

    // Next-state for pointers and sticky flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q && !ERR_CLR;
        udf_d    = udf_q && !ERR_CLR;
        if (push_ok_c) begin
            wr_ptr_d = wr_ptr_q + LW'(1);
        end
        if (pop_ok_c) begin
            rd_ptr_d = rd_ptr_q + LW'(1);
        end
        if (WR_EN && !push_ok_c) begin
            ovf_d = 1'b1;
        end
        if (RD_EN && empty_c) begin
            udf_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_mem #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (PCLK),
        .we_i    (push_ok_c),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (DATA_IN),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (rdata_c)
    );

    // Head word is masked while empty so stale storage never leaks out.
    assign DATA_OUT    = empty_c ? '0 : rdata_c;
    assign EMPTY       = empty_c;
    assign FULL        = full_c;
    assign LEVEL       = level_c;
    assign ALMOST_FULL = (level_c >= LW'(AF_LEVEL));
    assign OVERFLOW    = ovf_q;
    assign UNDERFLOW   = udf_q;

endmodule

// File: tb/tb_i2c_fifo.sv
// Self-checking bench for i2c_fifo (DEPTH=4, AF_LEVEL=3) with a queue scoreboard.
module tb_i2c_fifo;

    localparam int unsigned DW  = 32;
    localparam int unsigned DEP = 4;
    localparam int unsigned AFL = 3;

    logic          PCLK;
    logic          PRESETn;
    logic          WR_EN;
    logic [DW-1:0] DATA_IN;
    logic          RD_EN;
    logic [DW-1:0] DATA_OUT;
    logic          EMPTY;
    logic          FULL;
    logic          ALMOST_FULL;
    logic [2:0]    LEVEL;
    logic          OVERFLOW;
    logic          UNDERFLOW;
    logic          ERR_CLR;

    i2c_fifo #(
        .DWIDTH   (DW),
        .DEPTH    (DEP),
        .AF_LEVEL (AFL)
    ) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .WR_EN       (WR_EN),
        .DATA_IN     (DATA_IN),
        .RD_EN       (RD_EN),
        .DATA_OUT    (DATA_OUT),
        .EMPTY       (EMPTY),
        .FULL        (FULL),
        .ALMOST_FULL (ALMOST_FULL),
        .LEVEL       (LEVEL),
        .OVERFLOW    (OVERFLOW),
        .UNDERFLOW   (UNDERFLOW),
        .ERR_CLR     (ERR_CLR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    logic [DW-1:0] sb[$];
    bit            m_ovf;
    bit            m_udf;
    int            n_cmp;
    int            n_err;

    // One clock cycle of stimulus; updates the model and checks popped data against the scoreboard.
    task automatic step(input logic wr, input logic [DW-1:0] din, input logic rd, input logic clr);
        bit            m_empty, m_full, push_ok, pop_ok;
        logic [DW-1:0] exp;
        WR_EN   = wr;
        DATA_IN = din;
        RD_EN   = rd;
        ERR_CLR = clr;
        m_empty = (sb.size() == 0);
        m_full  = (sb.size() == DEP);
        pop_ok  = rd && !m_empty;
        push_ok = wr && (!m_full || pop_ok);
        if (pop_ok) begin
            n_cmp++;
            if (DATA_OUT !== sb[0]) begin
                n_err++;
                $display("FAIL pop_data: got %h expected %h", DATA_OUT, sb[0]);
            end
        end
        @(posedge PCLK);
        #1;
        if (pop_ok) exp = sb.pop_front();
        if (push_ok) sb.push_back(din);
        m_ovf = (wr && !push_ok) || (m_ovf && !clr);
        m_udf = (rd && m_empty) || (m_udf && !clr);
        WR_EN   = 1'b0;
        RD_EN   = 1'b0;
        ERR_CLR = 1'b0;
    endtask

    task automatic test_reset();
        WR_EN = 0; RD_EN = 0; ERR_CLR = 0; DATA_IN = '0;
        PRESETn = 1'b0;
        #23;
        n_cmp++;
        if ({EMPTY, FULL, ALMOST_FULL, OVERFLOW, UNDERFLOW} !== 5'b10000) begin
            n_err++;
            $display("FAIL reset_flags: got E%b F%b AF%b O%b U%b expected E1 F0 AF0 O0 U0",
                     EMPTY, FULL, ALMOST_FULL, OVERFLOW, UNDERFLOW);
        end
        n_cmp++;
        if (LEVEL !== 3'd0 || DATA_OUT !== '0) begin
            n_err++;
            $display("FAIL reset_level_data: got level %0d data %h expected 0 / 0", LEVEL, DATA_OUT);
        end
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(posedge PCLK);
        #1;
        sb.delete();
        m_ovf = 0;
        m_udf = 0;
    endtask

    task automatic test_fill();
        logic [DW-1:0] vals [4];
        vals[0] = 32'hA1; vals[1] = 32'hB2; vals[2] = 32'hC3; vals[3] = 32'hD4;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, vals[i], 1'b0, 1'b0);
            n_cmp++;
            if (LEVEL !== 3'(i + 1) || ALMOST_FULL !== ((i + 1) >= AFL) || DATA_OUT !== 32'hA1) begin
                n_err++;
                $display("FAIL fill_%0d: got level %0d af %b data %h expected %0d %b a1",
                         i, LEVEL, ALMOST_FULL, DATA_OUT, i + 1, (i + 1) >= AFL);
            end
        end
        n_cmp++;
        if (FULL !== 1'b1 || EMPTY !== 1'b0) begin
            n_err++;
            $display("FAIL fill_full: got full %b empty %b expected 1 0", FULL, EMPTY);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
        end
        n_cmp++;
        if (EMPTY !== 1'b1 || DATA_OUT !== '0 || UNDERFLOW !== 1'b0 || LEVEL !== 3'd0) begin
            n_err++;
            $display("FAIL drain_end: got empty %b data %h udf %b level %0d expected 1 0 0 0",
                     EMPTY, DATA_OUT, UNDERFLOW, LEVEL);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h10 + DW'(i), 1'b0, 1'b0);
        end
        step(1'b1, 32'hEE, 1'b0, 1'b0);
        n_cmp++;
        if (OVERFLOW !== 1'b1 || LEVEL !== 3'd4 || DATA_OUT !== sb[0]) begin
            n_err++;
            $display("FAIL overflow_set: got ovf %b level %0d data %h expected 1 4 %h",
                     OVERFLOW, LEVEL, DATA_OUT, sb[0]);
        end
        step(1'b0, '0, 1'b0, 1'b1);
        n_cmp++;
        if (OVERFLOW !== 1'b0 || LEVEL !== 3'd4) begin
            n_err++;
            $display("FAIL overflow_clr: got ovf %b level %0d expected 0 4", OVERFLOW, LEVEL);
        end
    endtask

    task automatic test_full_rw();
        step(1'b1, 32'h55, 1'b1, 1'b0);
        n_cmp++;
        if (LEVEL !== 3'd4 || OVERFLOW !== 1'b0 || DATA_OUT !== sb[0] || FULL !== 1'b1) begin
            n_err++;
            $display("FAIL full_rw: got level %0d ovf %b data %h full %b expected 4 0 %h 1",
                     LEVEL, OVERFLOW, DATA_OUT, FULL, sb[0]);
        end
        // Drain; scoreboard expects the 55 word on the fourth pop.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
        end
        n_cmp++;
        if (EMPTY !== 1'b1 || UNDERFLOW !== 1'b0) begin
            n_err++;
            $display("FAIL full_rw_drain: got empty %b udf %b expected 1 0", EMPTY, UNDERFLOW);
        end
    endtask

    task automatic test_empty_rw();
        step(1'b1, 32'h77, 1'b1, 1'b0);
        n_cmp++;
        if (UNDERFLOW !== 1'b1 || LEVEL !== 3'd1 || DATA_OUT !== 32'h77 || m_udf !== 1'b1) begin
            n_err++;
            $display("FAIL empty_rw: got udf %b level %0d data %h expected 1 1 77", UNDERFLOW, LEVEL, DATA_OUT);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        n_cmp++;
        if (UNDERFLOW !== 1'b1) begin
            n_err++;
            $display("FAIL udf_set_wins: got udf %b expected 1", UNDERFLOW);
        end
        step(1'b0, '0, 1'b0, 1'b1);
        n_cmp++;
        if (UNDERFLOW !== m_udf || UNDERFLOW !== 1'b0) begin
            n_err++;
            $display("FAIL udf_clr: got udf %b expected 0", UNDERFLOW);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            step(1'b1, $urandom, 1'b1, 1'b0);
            n_cmp++;
            if (LEVEL !== 3'(sb.size()) || DATA_OUT !== sb[0]) begin
                n_err++;
                $display("FAIL b2b_%0d: got level %0d data %h expected %0d %h",
                         i, LEVEL, DATA_OUT, sb.size(), sb[0]);
            end
        end
        step(1'b1, $urandom, 1'b0, 1'b0);
        n_cmp++;
        if (LEVEL !== 3'd2) begin
            n_err++;
            $display("FAIL b2b_level2: got level %0d expected 2", LEVEL);
        end
        // Asynchronous reset between edges.
        #2;
        PRESETn = 1'b0;
        #1;
        n_cmp++;
        if (EMPTY !== 1'b1 || LEVEL !== 3'd0 || DATA_OUT !== '0) begin
            n_err++;
            $display("FAIL async_reset: got empty %b level %0d data %h expected 1 0 0", EMPTY, LEVEL, DATA_OUT);
        end
        sb.delete();
        m_ovf = 0;
        m_udf = 0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(posedge PCLK);
        #1;
        step(1'b1, 32'h99, 1'b0, 1'b0);
        n_cmp++;
        if (DATA_OUT !== 32'h99 || LEVEL !== 3'd1) begin
            n_err++;
            $display("FAIL post_reset_push: got data %h level %0d expected 99 1", DATA_OUT, LEVEL);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        n_cmp++;
        if (EMPTY !== 1'b1 || OVERFLOW !== m_ovf || UNDERFLOW !== m_udf) begin
            n_err++;
            $display("FAIL post_reset_pop: got empty %b ovf %b udf %b expected 1 %b %b",
                     EMPTY, OVERFLOW, UNDERFLOW, m_ovf, m_udf);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_fill();
        test_drain();
        test_overflow();
        test_full_rw();
        test_empty_rw();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
